// File: rtl/line_rasterizer.sv
// Bresenham line rasterizer: accepts one segment per start/ready handshake and
// emits one frame-buffer pixel write per clock. Write-bus outputs are zero
// whenever no write is happening, so the bus can be OR-merged with other writers.
// Optional build macro LINE_RASTERIZER_CLIP_EN suppresses writes for off-screen pixels.
module line_rasterizer #(
    parameter int unsigned HOR_ACTIVE_PIXELS = 640,
    parameter int unsigned VER_ACTIVE_PIXELS = 480,
    parameter int unsigned X_WIDTH           = $clog2(HOR_ACTIVE_PIXELS),
    parameter int unsigned Y_WIDTH           = $clog2(VER_ACTIVE_PIXELS),
    parameter int unsigned ADDR_WIDTH        = $clog2(HOR_ACTIVE_PIXELS * VER_ACTIVE_PIXELS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  ready,
    input  logic [X_WIDTH-1:0]    x1,
    input  logic [Y_WIDTH-1:0]    y1,
    input  logic [X_WIDTH-1:0]    x2,
    input  logic [Y_WIDTH-1:0]    y2,
    output logic                  write_enable,
    output logic [ADDR_WIDTH-1:0] write_addr,
    output logic                  write_data
);

    // Signed error-term width; wide enough for any pair of X_WIDTH-bit coordinates.
    localparam int unsigned CW = X_WIDTH + 2;
    localparam logic [ADDR_WIDTH-1:0] ROW_STEP = ADDR_WIDTH'(HOR_ACTIVE_PIXELS);

    typedef enum logic [1:0] {StIdle, StSetup, StDraw} state_t;

    state_t                 state_q, state_d;
    logic [X_WIDTH-1:0]     x_q, x_d, xe_q, xe_d;
    logic [Y_WIDTH-1:0]     y_q, y_d, ye_q, ye_d;
    logic signed [CW-1:0]   dx_q, dx_d, dy_q, dy_d, err_q, err_d;
    logic                   sx_neg_q, sx_neg_d, sy_neg_q, sy_neg_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;

    logic signed [CW-1:0]   diff_x, diff_y, abs_dx, abs_dy;
    logic signed [CW:0]     e2, dx_ext, dy_ext;
    logic [ADDR_WIDTH-1:0]  base_addr;
    logic                   step_x, step_y, at_end, in_range;

    // Setup arithmetic: current point holds (x1,y1), xe/ye hold the endpoint.
    assign diff_x    = $signed({2'b00, xe_q}) - $signed({2'b00, x_q});
    assign diff_y    = $signed({{(CW - Y_WIDTH){1'b0}}, ye_q})
                     - $signed({{(CW - Y_WIDTH){1'b0}}, y_q});
    assign abs_dx    = diff_x[CW-1] ? -diff_x : diff_x;
    assign abs_dy    = diff_y[CW-1] ? -diff_y : diff_y;
    assign base_addr = ADDR_WIDTH'(y_q) * ROW_STEP + ADDR_WIDTH'(x_q);

    // Per-pixel step decision from e2 = 2*err.
    assign e2     = $signed({err_q, 1'b0});
    assign dx_ext = $signed({dx_q[CW-1], dx_q});
    assign dy_ext = $signed({dy_q[CW-1], dy_q});
    assign step_x = (e2 >= dy_ext);
    assign step_y = (e2 <= dx_ext);
    assign at_end = (x_q == xe_q) && (y_q == ye_q);

`ifdef LINE_RASTERIZER_CLIP_EN
    localparam logic [X_WIDTH-1:0] X_LIMIT = X_WIDTH'(HOR_ACTIVE_PIXELS);
    localparam logic [Y_WIDTH-1:0] Y_LIMIT = Y_WIDTH'(VER_ACTIVE_PIXELS);
    assign in_range = (x_q < X_LIMIT) && (y_q < Y_LIMIT);
`else
    assign in_range = 1'b1;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and handshake.
    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
        unique case (state_q)
            StIdle: begin
                ready = 1'b1;
                if (start) state_d = StSetup;
            end
            StSetup: state_d = StDraw;
            StDraw:  if (at_end) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Datapath next values: latch on accept, initialise in setup, step in draw.
    always_comb begin
        x_d      = x_q;
        y_d      = y_q;
        xe_d     = xe_q;
        ye_d     = ye_q;
        dx_d     = dx_q;
        dy_d     = dy_q;
        err_d    = err_q;
        sx_neg_d = sx_neg_q;
        sy_neg_d = sy_neg_q;
        addr_d   = addr_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    x_d  = x1;
                    y_d  = y1;
                    xe_d = x2;
                    ye_d = y2;
                end
            end
            StSetup: begin
                dx_d     = abs_dx;
                dy_d     = -abs_dy;
                err_d    = abs_dx - abs_dy;
                sx_neg_d = diff_x[CW-1];
                sy_neg_d = diff_y[CW-1];
                addr_d   = base_addr;
            end
            StDraw: begin
                if (!at_end) begin
                    // Both axis updates may fire in the same cycle.
                    if (step_x) begin
                        err_d  = err_d + dy_q;
                        x_d    = sx_neg_q ? x_q - X_WIDTH'(1) : x_q + X_WIDTH'(1);
                        addr_d = sx_neg_q ? addr_d - ADDR_WIDTH'(1) : addr_d + ADDR_WIDTH'(1);
                    end
                    if (step_y) begin
                        err_d  = err_d + dx_q;
                        y_d    = sy_neg_q ? y_q - Y_WIDTH'(1) : y_q + Y_WIDTH'(1);
                        addr_d = sy_neg_q ? addr_d - ROW_STEP : addr_d + ROW_STEP;
                    end
                end
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q      <= '0;
            y_q      <= '0;
            xe_q     <= '0;
            ye_q     <= '0;
            dx_q     <= '0;
            dy_q     <= '0;
            err_q    <= '0;
            sx_neg_q <= 1'b0;
            sy_neg_q <= 1'b0;
            addr_q   <= '0;
        end else begin
            x_q      <= x_d;
            y_q      <= y_d;
            xe_q     <= xe_d;
            ye_q     <= ye_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
            err_q    <= err_d;
            sx_neg_q <= sx_neg_d;
            sy_neg_q <= sy_neg_d;
            addr_q   <= addr_d;
        end
    end

    // Write bus: all zero unless a pixel is actually written this cycle.
    always_comb begin
        write_enable = 1'b0;
        write_addr   = '0;
        write_data   = 1'b0;
        if (state_q == StDraw && in_range) begin
            write_enable = 1'b1;
            write_addr   = addr_q;
            write_data   = 1'b1;
        end
    end

endmodule
